// File: rtl/button_event_gen.sv
// Button event producer: synchronise, debounce, press/release pulses and hold-to-repeat
// for N_BTN active-low switches, one independent lane per button.

module button_event_lane #(
    parameter int DEB_CYCLES    = 20000,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb,
    output logic press,
    output logic rpt,
    output logic rel,
    output logic long_q
);
    // The arm qualifier needs at least 3 samples so the 2-flop sync reset value
    // (released) can never be mistaken for a genuine release after RST.
    localparam int ARM_CYCLES = (DEB_CYCLES < 3) ? 3 : DEB_CYCLES;
    localparam int CW         = $clog2(ARM_CYCLES) + 1;
    localparam int TMAX       = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW         = $clog2(TMAX) + 1;

    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] ARM_LAST = CW'(ARM_CYCLES - 1);
    localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

    localparam logic [1:0] ARM_WAIT = 2'd0;
    localparam logic [1:0] IDLE     = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] REPT     = 2'd3;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] arm_cnt;
    logic [TW-1:0] timer;
    logic [1:0]    state;
    logic          s;
    logic          deb_hit;
    logic          fall;
    logic          rise;

    assign s       = sync_q[1];
    assign deb_hit = (s != deb) && (cnt == DEB_LAST);
    assign fall    = deb_hit && !s;
    assign rise    = deb_hit && s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            deb     <= 1'b1;
            cnt     <= '0;
            arm_cnt <= '0;
            timer   <= '0;
            state   <= ARM_WAIT;
            press   <= 1'b0;
            rpt     <= 1'b0;
            rel     <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            press  <= 1'b0;
            rpt    <= 1'b0;
            rel    <= 1'b0;

            if (s == deb) begin
                cnt <= '0;
            end else if (deb_hit) begin
                deb <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                ARM_WAIT: begin
                    // Only a confirmed stable release arms the lane; levels seen here emit nothing.
                    if (deb && s) begin
                        if (arm_cnt == ARM_LAST) begin
                            state   <= IDLE;
                            arm_cnt <= '0;
                        end else begin
                            arm_cnt <= arm_cnt + 1'b1;
                        end
                    end else begin
                        arm_cnt <= '0;
                    end
                end
                IDLE: begin
                    if (fall) begin
                        press <= 1'b1;
                        timer <= '0;
                        state <= HELD;
                    end
                end
                HELD: begin
                    if (rise) begin
                        rel   <= 1'b1;
                        state <= IDLE;
                    end else if (REPEAT_EN && timer == DLY_LAST) begin
                        press  <= 1'b1;
                        rpt    <= 1'b1;
                        long_q <= 1'b1;
                        timer  <= '0;
                        state  <= REPT;
                    end else if (REPEAT_EN) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    if (rise) begin
                        rel    <= 1'b1;
                        long_q <= 1'b0;
                        state  <= IDLE;
                    end else if (timer == PER_LAST) begin
                        press <= 1'b1;
                        rpt   <= 1'b1;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

module button_event_gen #(
    parameter int               N_BTN         = 3,
    parameter int               DEB_CYCLES    = 20000,
    parameter int               REPEAT_DELAY  = 500000,
    parameter int               REPEAT_PERIOD = 100000,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = 3'b011
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] BTN_RAW,
    output logic [N_BTN-1:0] BTN_DEB,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_REPEAT,
    output logic [N_BTN-1:0] BTN_RELEASE,
    output logic [N_BTN-1:0] BTN_LONG
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_lane
        button_event_lane #(
            .DEB_CYCLES   (DEB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .REPEAT_EN    (REPEAT_MASK[i])
        ) u_lane (
            .clk   (CLK),
            .rst   (RST),
            .raw   (BTN_RAW[i]),
            .deb   (BTN_DEB[i]),
            .press (BTN_PRESS[i]),
            .rpt   (BTN_REPEAT[i]),
            .rel   (BTN_RELEASE[i]),
            .long_q(BTN_LONG[i])
        );
    end
endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with short debounce/repeat timing.

module tb_button_event_gen;
    logic       clk;
    logic       rst;
    logic [2:0] raw;
    logic [2:0] deb, press, rpt, rel, lng;

    int n_chk  = 0;
    int n_fail = 0;
    int pc [3] = '{0, 0, 0};
    int rc [3] = '{0, 0, 0};
    int lc [3] = '{0, 0, 0};
    int base_p, base_r, base_l;

    button_event_gen #(
        .N_BTN(3), .DEB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8),
        .REPEAT_MASK(3'b011)
    ) dut (
        .CLK(clk), .RST(rst), .BTN_RAW(raw), .BTN_DEB(deb), .BTN_PRESS(press),
        .BTN_REPEAT(rpt), .BTN_RELEASE(rel), .BTN_LONG(lng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse counters for whole-window checks
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (press[i]) pc[i] = pc[i] + 1;
            if (rel[i])   rc[i] = rc[i] + 1;
            if (rpt[i])   lc[i] = lc[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        raw = 3'b111;
        step(2);
        check("rst_deb", 32'(deb), 32'h7);
        check("rst_press", 32'(press), 32'h0);
        check("rst_long", 32'(lng), 32'h0);
        rst = 1'b0;
        step(12);

        // 1: three-sample glitch rejected
        base_p = pc[0];
        raw[0] = 1'b0;
        step(3);
        raw[0] = 1'b1;
        step(3);
        check("t1_deb_mid", 32'(deb), 32'h7);
        step(10);
        check("t1_deb", 32'(deb), 32'h7);
        check("t1_press_cnt", 32'(pc[0] - base_p), 32'h0);

        // 2: press latency DEB+1, release symmetric
        raw[0] = 1'b0;
        step(5);
        check("t2_deb_e4", 32'(deb), 32'h7);
        check("t2_press_e4", 32'(press), 32'h0);
        step(1);
        check("t2_deb_e5", 32'(deb), 32'h6);
        check("t2_press_e5", 32'(press), 32'h1);
        check("t2_rpt_e5", 32'(rpt), 32'h0);
        step(1);
        check("t2_press_e6", 32'(press), 32'h0);
        step(2);
        raw[0] = 1'b1;
        step(5);
        check("t2_rel_e4", 32'(rel), 32'h0);
        step(1);
        check("t2_rel_e5", 32'(rel), 32'h1);
        check("t2_deb_rel", 32'(deb), 32'h7);
        step(1);
        check("t2_rel_e6", 32'(rel), 32'h0);
        step(10);

        // 3: hold-to-repeat on button 1, release coinciding with a due repeat
        raw[1] = 1'b0;
        step(6);
        check("t3_press_p", 32'(press), 32'h2);
        check("t3_rpt_p", 32'(rpt), 32'h0);
        step(19);
        check("t3_press_p19", 32'(press), 32'h0);
        check("t3_long_p19", 32'(lng), 32'h0);
        step(1);
        check("t3_press_p20", 32'(press), 32'h2);
        check("t3_rpt_p20", 32'(rpt), 32'h2);
        check("t3_long_p20", 32'(lng), 32'h2);
        step(7);
        check("t3_press_p27", 32'(press), 32'h0);
        step(1);
        check("t3_rpt_p28", 32'(rpt), 32'h2);
        step(8);
        check("t3_press_p36", 32'(press), 32'h2);
        check("t3_rpt_p36", 32'(rpt), 32'h2);
        step(2);
        raw[1] = 1'b1;
        step(5);
        check("t3_long_p43", 32'(lng), 32'h2);
        check("t3_rel_p43", 32'(rel), 32'h0);
        step(1);
        check("t3_rel_p44", 32'(rel), 32'h2);
        check("t3_press_p44", 32'(press), 32'h0);
        check("t3_long_p44", 32'(lng), 32'h0);
        base_p = pc[1];
        step(20);
        check("t3_no_more", 32'(pc[1] - base_p), 32'h0);

        // 4: no repeat when masked
        base_p = pc[2]; base_r = rc[2]; base_l = lc[2];
        raw[2] = 1'b0;
        step(50);
        check("t4_long_mid", 32'(lng), 32'h0);
        step(50);
        raw[2] = 1'b1;
        step(10);
        check("t4_press_cnt", 32'(pc[2] - base_p), 32'h1);
        check("t4_rel_cnt", 32'(rc[2] - base_r), 32'h1);
        check("t4_rpt_cnt", 32'(lc[2] - base_l), 32'h0);

        // 5: held through reset stays silent until released and pressed again
        raw[0] = 1'b0;
        step(10);
        rst = 1'b1;
        step(2);
        check("t5_rst_deb", 32'(deb), 32'h7);
        check("t5_rst_press", 32'(press), 32'h0);
        rst = 1'b0;
        base_p = pc[0]; base_r = rc[0];
        step(15);
        check("t5_press_cnt", 32'(pc[0] - base_p), 32'h0);
        check("t5_deb_held", 32'(deb), 32'h6);
        raw[0] = 1'b1;
        step(15);
        check("t5_rel_cnt", 32'(rc[0] - base_r), 32'h0);
        raw[0] = 1'b0;
        step(6);
        check("t5_repress", 32'(press), 32'h1);
        raw[0] = 1'b1;
        step(15);

        // 6: simultaneous press, reset before first repeat
        raw[1:0] = 2'b00;
        step(6);
        check("t6_press_p", 32'(press), 32'h3);
        step(15);
        rst = 1'b1;
        step(1);
        check("t6_rst_deb", 32'(deb), 32'h7);
        check("t6_rst_press", 32'(press), 32'h0);
        check("t6_rst_long", 32'(lng), 32'h0);
        step(1);
        rst = 1'b0;
        base_p = pc[0] + pc[1];
        step(20);
        check("t6_no_repeat", 32'(pc[0] + pc[1] - base_p), 32'h0);
        check("t6_long", 32'(lng), 32'h0);
        raw = 3'b111;
        step(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
